stopwatch_display_scan: RTL
===========================

// Module: stopwatch_display_scan
// PURPOSE
//  Time-multiplexed 4-digit seven-segment driver fed directly by the stopwatch
//  digit outputs (min0, sec1, sec0, milSec0 BCD). Takes a coherent snapshot of
//  all four digits once per frame, scans the anodes with a blanking gap, and
//  decodes BCD to segments. Drives the board display pins, shown as M.SS.m.
// PARAMETERS
//  SCAN_DIV      1000  clk cycles per digit slot (>= 2)
//  BLANK_CYCLES  4     cycles at slot start with all anodes off (1 .. SCAN_DIV-1)
//  ACTIVE_LOW    1     1: seg/an/dp active-low; 0: active-high
// PORTS
//  clk          in   1  system clock, the same clock as the stopwatch
//  reset        in   1  synchronous, active-high
//  min0         in   4  BCD minutes digit
//  sec1         in   4  BCD tens-of-seconds digit
//  sec0         in   4  BCD seconds digit
//  milSec0      in   4  BCD tenths digit
//  seg          out  7  {g,f,e,d,c,b,a}, registered
//  dp           out  1  decimal point, registered
//  an           out  4  anode enables, an[0] rightmost, registered
//  frame_start  out  1  1-cycle pulse when the snapshot is loaded, registered
// BEHAVIOUR
//  Clock and reset:
//  - One clock (clk). reset is synchronous and active-high.
//  - Reset: div_cnt=0, idx=0, snapshot=16'h0000, all outputs inactive:
//    seg/an/dp = all 1s if ACTIVE_LOW, else all 0s. frame_start=0.
//  Counters:
//  - div_cnt counts 0..SCAN_DIV-1, then wraps to 0 and idx increments.
//  - idx (2 bits) wraps 3->0.
//  Snapshot:
//  - Loaded when div_cnt==0 && idx==0. This includes the first cycle after
//    reset deasserts.
//  - Contents {min0,sec1,sec0,milSec0}.
//  - frame_start=1 in the following cycle.
//  - Input changes mid-frame never appear until the next frame. No tearing.
//  Digit map: idx0=milSec0, idx1=sec0, idx2=sec1, idx3=min0.
//  Outputs are registered from (idx, div_cnt, snapshot); latency is 1 cycle.
//  - div_cnt < BLANK_CYCLES: an all inactive, seg and dp inactive.
//  - Otherwise: an[idx] active only; seg = decode(snapshot digit idx).
//  - dp is active on idx3 and idx1 only.
//  Decode (active-high, {g..a}):
//  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//  - Non-BCD values (A-F) show a dash = 40.
//  - ACTIVE_LOW inverts seg, an and dp together at the output register.
//  Boundaries:
//  - A frame is 4*SCAN_DIV cycles, periodic and free-running. No enable input.
//  - Reset asserted mid-slot: the next cycle forces the reset state, and the
//    scan restarts at idx0 with a fresh snapshot.
//  - At most one anode is ever active. Blanking guarantees zero overlap
//    between consecutive digits.
// CONFIGURATION
//  Macro LEADING_ZERO_BLANK_EN, applied to the snapshot at decode time:
//  - Defined: idx3 (min0) is blanked (seg inactive, an still active, dp kept)
//    when min0==0.
//  - Defined: idx2 (sec1) is blanked when min0==0 && sec1==0.
//  - Defined: idx1 and idx0 are never blanked.
//  - Undefined: all digits always shown, including zeros.
// TESTING
//  Bench parameters: SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=0.
//  1 Reset held 3 cycles -> seg=0, an=0, dp=0, frame_start=0. Release ->
//    frame_start=1 in cycle 1. an=0001 first appears in cycle 3.
//  2 Digits 1,2,3,4 (min0..milSec0) ->
//    - slot idx0: an=0001 seg=66
//    - slot idx1: an=0010 seg=4F dp=1
//    - slot idx2: an=0100 seg=5B
//    - slot idx3: an=1000 seg=06 dp=1
//    - each slot shows 6 lit cycles after 2 blank cycles.
//  3 Change milSec0 4->7 in mid-frame (slot idx2) -> idx0 keeps 66 until next
//    frame_start. Then seg=07 in slot idx0.
//  4 milSec0=4'hB -> seg=40 (dash) in slot idx0.
//  5 Assert reset in the middle of slot idx2 -> the next cycle shows the reset
//    state. After release the scan restarts at idx0 with a new snapshot.
//  6 LEADING_ZERO_BLANK_EN defined, digits 0,0,5,3 ->
//    - idx3: seg=0, dp=1
//    - idx2: seg=0
//    - idx1: seg=6D
//    - idx0: seg=4F
//  7 Check that at most one bit of an is ever active.

Source files
------------

// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan
// Four-digit multiplexed seven-segment driver for the stopwatch (M.SS.m).
// A coherent snapshot of the digits is taken at the start of every frame,
// the anodes are scanned right to left with a short blanking gap per slot,
// and the selected BCD digit is decoded to segments.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zeros on
// the minutes and tens-of-seconds digits).

module stopwatch_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [3:0] milSec0,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    // Polarity mask: XOR with these turns active-high values into pin levels.
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
    localparam logic       DP_POL  = ACTIVE_LOW;

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      snapshot;
    logic             load_snapshot;

    logic [3:0] cur_digit;
    logic       lit;
    logic       zero_blank;
    logic [6:0] seg_raw;
    logic [3:0] an_raw;
    logic       dp_raw;

    // BCD to active-high {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
    function automatic logic [6:0] decode_bcd(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
        return pattern;
    endfunction

    // The snapshot is taken on the first cycle of every frame, including the
    // first cycle after reset is released, since reset parks the counters there.
    assign load_snapshot = (div_cnt == '0) && (idx == 2'd0);

    // Slot timer and digit index: free-running, one frame every 4*SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (div_cnt == CNT_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Frame snapshot so a digit rolling over mid-frame can never tear the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= 16'h0000;
        end else if (load_snapshot) begin
            snapshot <= {min0, sec1, sec0, milSec0};
        end
    end

    // Select the digit for this slot and build active-high segment/anode values.
    always_comb begin
        cur_digit  = 4'd0;
        zero_blank = 1'b0;
        seg_raw    = 7'h00;
        an_raw     = 4'b0000;
        dp_raw     = 1'b0;

        case (idx)
            2'd0:    cur_digit = snapshot[3:0];
            2'd1:    cur_digit = snapshot[7:4];
            2'd2:    cur_digit = snapshot[11:8];
            default: cur_digit = snapshot[15:12];
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2'd3 && snapshot[15:12] == 4'd0) begin
            zero_blank = 1'b1;
        end
        if (idx == 2'd2 && snapshot[15:12] == 4'd0 && snapshot[11:8] == 4'd0) begin
            zero_blank = 1'b1;
        end
`else
        zero_blank = 1'b0;
`endif

        lit = (div_cnt >= CNT_BLANK);

        if (lit) begin
            an_raw  = 4'b0001 << idx;
            dp_raw  = idx[0];
            seg_raw = zero_blank ? 7'h00 : decode_bcd(cur_digit);
        end
    end

    // Output register: applies pin polarity and gives one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg         <= SEG_POL;
            an          <= AN_POL;
            dp          <= DP_POL;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_raw ^ SEG_POL;
            an          <= an_raw ^ AN_POL;
            dp          <= dp_raw ^ DP_POL;
            frame_start <= load_snapshot;
        end
    end

endmodule
